// File: rtl/uart_rx_fifo_gen2.sv
// Oversampled UART receiver with runtime framing config,
// 3-sample majority bit voting and a small valid/ready FIFO.
module uart_rx_fifo_gen2 #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int PRESCALE_BITS  = 6,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_BITS-1:0]  Prescale,
  input  logic [3:0]                DATA_LEN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic                      DATA_READY,
  output logic [MAX_DATA_WIDTH-1:0] P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR,
  output logic                      OVERRUN
);
  localparam int PW = PRESCALE_BITS;
  localparam int DW = MAX_DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2
  } state_e;

  state_e          state_q, state_d;
  logic            rx_m_q, rx_s_q, rx_p_q;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [DW-1:0]   data_q, data_d;
  logic [PW-1:0]   p_q, p_d;
  logic [3:0]      len_q, len_d;
  logic            pen_q, pen_d;
  logic            ptyp_q, ptyp_d;
  logic            stop2_q, stop2_d;
  logic [1:0]      smp_q, smp_d;
  logic            perr_q, perr_d;
  logic            serr_q, serr_d;
  logic            par_err_q, par_err_d;
  logic            stp_err_q, stp_err_d;
  logic            ovr_q, ovr_d;
  logic [DW-1:0]   mem_q [FIFO_DEPTH];
  logic [DW-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;

  logic          fall, maj, done, leave;
  logic          push, pop, full, good;
  logic [PW-1:0] mid;

  assign fall = rx_p_q & ~rx_s_q;
  assign mid  = p_q >> 1;
  assign maj  = (smp_q[0] & smp_q[1]) |
                (smp_q[0] & rx_s_q) |
                (smp_q[1] & rx_s_q);

  // State, synchroniser, config latch and FIFO registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_p_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      p_q       <= PW'(4);
      len_q     <= 4'd5;
      pen_q     <= 1'b0;
      ptyp_q    <= 1'b0;
      stop2_q   <= 1'b0;
      smp_q     <= 2'b11;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      ovr_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
    end else begin
      rx_m_q    <= RX_IN;
      rx_s_q    <= rx_m_q;
      rx_p_q    <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      p_q       <= p_d;
      len_q     <= len_d;
      pen_q     <= pen_d;
      ptyp_q    <= ptyp_d;
      stop2_q   <= stop2_d;
      smp_q     <= smp_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
      ovr_q     <= ovr_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
    end
  end

  // Frame sequencing: bit timing, voting, shifting, error capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    p_d     = p_q;
    len_d   = len_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    stop2_d = stop2_q;
    smp_d   = smp_q;
    perr_d  = perr_q;
    serr_d  = serr_q;
    done    = 1'b0;
    leave   = 1'b0;
    if (state_q == S_IDLE) begin
      if (fall) begin
        state_d = S_START;
        cnt_d   = '0;
        bit_d   = '0;
        data_d  = '0;
        perr_d  = 1'b0;
        serr_d  = 1'b0;
        p_d     = (Prescale < PW'(4)) ? PW'(4) : Prescale;
        len_d   = (DATA_LEN < 4'd5) ? 4'd5 :
                  (DATA_LEN > 4'(DW)) ? 4'(DW) : DATA_LEN;
        pen_d   = PAR_EN;
        ptyp_d  = PAR_TYP;
        stop2_d = STOP2;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == mid - 1'b1) smp_d[0] = rx_s_q;
      if (cnt_q == mid)        smp_d[1] = rx_s_q;
      if (cnt_q == mid + 1'b1) begin
        unique case (state_q)
          S_START: leave = maj;
          S_DATA:  data_d[bit_q] = maj;
          S_PAR:   if (maj != (^data_q ^ ptyp_q)) perr_d = 1'b1;
          S_STOP1: begin
            if (!maj) serr_d = 1'b1;
            if (!stop2_q) begin
              done  = 1'b1;
              leave = 1'b1;
            end
          end
          S_STOP2: begin
            if (!maj) serr_d = 1'b1;
            done  = 1'b1;
            leave = 1'b1;
          end
          default: ;
        endcase
      end
      if (leave) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else if (cnt_q == p_q - 1'b1) begin
        cnt_d = '0;
        unique case (state_q)
          S_START: begin
            state_d = S_DATA;
            bit_d   = '0;
          end
          S_DATA: begin
            if (bit_q == len_q - 1'b1)
              state_d = pen_q ? S_PAR : S_STOP1;
            else
              bit_d = bit_q + 1'b1;
          end
          S_PAR:   state_d = S_STOP1;
          S_STOP1: state_d = S_STOP2;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Completion outcome, FIFO push/pop and flag pulses
  always_comb begin
    pop       = (count_q != '0) & DATA_READY;
    full      = (count_q == CW'(FIFO_DEPTH));
    good      = done & ~perr_q & ~serr_d;
    push      = good & (~full | pop);
    par_err_d = done & perr_q;
    stp_err_d = done & serr_d;
    ovr_d     = good & full & ~pop;
    mem_d     = mem_q;
    if (push) mem_d[wr_q] = data_q;
    wr_d      = wr_q + AW'(push);
    rd_d      = rd_q + AW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
  end

  assign DATA_VALID = (count_q != '0);
  assign P_DATA     = DATA_VALID ? mem_q[rd_q] : '0;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;
  assign OVERRUN    = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo_gen2.sv
// Bench for uart_rx_fifo_gen2: directed frames plus random
// frames scored against a frame-level reference model.
module tb_uart_rx_fifo_gen2;
  localparam int DW    = 9;
  localparam int PW    = 6;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] Prescale = 6'd8;
  logic [3:0]    DATA_LEN = 4'd8;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          STOP2 = 1'b0;
  logic          DATA_READY = 1'b1;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID, PAR_ERR, STP_ERR, OVERRUN;

  int n_cmp = 0;
  int n_bad = 0;
  int obs_perr = 0, obs_serr = 0, obs_ovr = 0;
  int exp_perr = 0, exp_serr = 0, exp_ovr = 0;
  int held = 0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 CLK = ~CLK;

  uart_rx_fifo_gen2 #(
    .MAX_DATA_WIDTH(DW),
    .PRESCALE_BITS(PW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN),
    .Prescale(Prescale), .DATA_LEN(DATA_LEN),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .DATA_READY(DATA_READY), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR),
    .STP_ERR(STP_ERR), .OVERRUN(OVERRUN)
  );

  // observe pulses and popped words away from the active edge
  always @(negedge CLK) begin
    if (RST) begin
      if (PAR_ERR) obs_perr++;
      if (STP_ERR) obs_serr++;
      if (OVERRUN) obs_ovr++;
      if (DATA_VALID && DATA_READY) got_q.push_back(P_DATA);
    end
  end

  task automatic chk(input string tag, input int unsigned got,
                     input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input int ps, input int dl, input bit pe,
                            input bit pt, input bit s2,
                            input int unsigned d, input bit bad_par,
                            input bit bad_s1, input bit bad_s2,
                            input int gap);
    int p, len;
    logic [DW-1:0] w;
    bit par, perr, serr;
    p   = (ps < 4) ? 4 : ps;
    len = (dl < 5) ? 5 : ((dl > DW) ? DW : dl);
    w   = DW'(d & ((32'd1 << len) - 1));
    par = ($countones(w) % 2 == 1) ^ pt ^ bad_par;
    Prescale = PW'(ps);
    DATA_LEN = 4'(dl);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    STOP2    = s2;
    drive_bit(1'b0, p);
    Prescale = PW'($urandom);
    DATA_LEN = 4'($urandom);
    PAR_EN   = 1'($urandom);
    PAR_TYP  = 1'($urandom);
    STOP2    = 1'($urandom);
    for (int i = 0; i < len; i++) drive_bit(w[i], p);
    if (pe) drive_bit(par, p);
    drive_bit(!bad_s1, p);
    if (s2) drive_bit(!bad_s2, p);
    RX_IN = 1'b1;
    if (gap > 0) drive_bit(1'b1, gap * p);
    perr = pe & bad_par;
    serr = bad_s1 | (s2 & bad_s2);
    if (perr) exp_perr++;
    if (serr) exp_serr++;
    if (!perr && !serr) begin
      if (!DATA_READY && held == DEPTH) exp_ovr++;
      else begin
        exp_q.push_back(w);
        if (!DATA_READY) held++;
      end
    end
  endtask

  task automatic settle(input string tag);
    repeat (80) @(posedge CLK);
    #1;
    chk({tag, "_cnt"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_word"}, got_q[i], exp_q[i]);
    chk({tag, "_perr"}, obs_perr, exp_perr);
    chk({tag, "_serr"}, obs_serr, exp_serr);
    chk({tag, "_ovr"}, obs_ovr, exp_ovr);
    got_q.delete();
    exp_q.delete();
    held = 0;
  endtask

  initial begin
    int nv;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_out", {P_DATA, DATA_VALID, PAR_ERR, STP_ERR, OVERRUN}, 0);
    RST = 1'b1;
    repeat (4) @(posedge CLK);
    #1;

    send_frame(8, 8, 1, 0, 0, 'hA5, 0, 0, 0, 2);
    settle("t1_good");
    send_frame(8, 8, 1, 0, 0, 'hA5, 1, 0, 0, 2);
    settle("t2_parity");
    send_frame(16, 7, 1, 1, 1, 'h3C, 0, 0, 1, 2);
    settle("t3_stop2bad");
    send_frame(16, 7, 1, 1, 1, 'h3C, 0, 0, 0, 2);
    settle("t3_good");

    Prescale = 6'd8;
    DATA_LEN = 4'd8;
    PAR_EN   = 1'b0;
    STOP2    = 1'b0;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 20);
    send_frame(8, 8, 0, 0, 0, 'h55, 0, 0, 0, 2);
    settle("t4_glitch");

    DATA_READY = 1'b0;
    for (int i = 1; i <= 5; i++)
      send_frame(8, 8, 0, 0, 0, i, 0, 0, 0, 0);
    drive_bit(1'b1, 40);
    chk("t5_ovr", obs_ovr, exp_ovr);
    DATA_READY = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (DATA_VALID) nv++;
    end
    chk("t5_drain_cycles", nv, 4);
    chk("t5_empty", DATA_VALID, 0);
    settle("t5_fifo");

    DATA_READY = 1'b0;
    send_frame(8, 8, 0, 0, 0, 'h11, 0, 0, 0, 2);
    drive_bit(1'b1, 10);
    chk("t6_held", DATA_VALID, 1);
    Prescale = 6'd8;
    DATA_LEN = 4'd8;
    PAR_EN   = 1'b0;
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 3);
    RST = 1'b0;
    #2;
    chk("t6_rst_out", {P_DATA, DATA_VALID, PAR_ERR, STP_ERR, OVERRUN}, 0);
    RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    exp_q.delete();
    held = 0;
    DATA_READY = 1'b1;
    drive_bit(1'b1, 8);
    send_frame(8, 8, 0, 0, 0, 'h9A, 0, 0, 0, 2);
    settle("t6_after_rst");

    for (int n = 0; n < 24; n++) begin
      send_frame($urandom_range(0, 20), $urandom_range(0, 15),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, 2);
      settle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
